mat_pow_dispatcher: RTL and testbench

- Initiator side of the matrix-power controller's start/Ready handshake.
- Accepts one operand matrix per job from an upstream valid/ready port and loads it onto the operand bus of the power datapath.
- Pulses op_start, waits for the controller's one-cycle Ready, captures the result matrix and hands it downstream on a valid/ready port.
- A watchdog flags jobs whose Ready never arrives, so a hung controller cannot stall the pipeline.

---
 rtl/mat_pow_dispatcher_if.sv | 32 +++
 rtl/mat_pow_dispatcher.sv | 126 ++++++++++++
 tb/tb_mat_pow_dispatcher.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mat_pow_dispatcher_if.sv
// Handshake and data bundle between the matrix-power dispatcher and its
// upstream job source, power datapath/controller and downstream consumer.
interface mat_pow_dispatcher_if #(
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned ELEMS  = 4
);
    localparam int unsigned DW = ELEM_W * ELEMS;

    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_mat;
    logic [DW-1:0] op_mat;
    logic          op_start;
    logic          core_ready;
    logic [DW-1:0] core_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_mat;
    logic          rsp_err;
    logic          busy;

    // master: the dispatcher itself; slave: everything around it
    modport master (
        input  req_valid, req_mat, core_ready, core_result, rsp_ready,
        output req_ready, op_mat, op_start, rsp_valid, rsp_mat, rsp_err, busy
    );

    modport slave (
        output req_valid, req_mat, core_ready, core_result, rsp_ready,
        input  req_ready, op_mat, op_start, rsp_valid, rsp_mat, rsp_err, busy
    );
endinterface

// File: rtl/mat_pow_dispatcher.sv
// Start/Ready initiator for the matrix-power controller, one job in flight, with a WAIT watchdog.
// Define MAT_POW_DISPATCHER_PERF_CNT_EN to add saturating job/error/wait-cycle counters.
module mat_pow_dispatcher #(
    parameter int unsigned ELEM_W  = 8,
    parameter int unsigned ELEMS   = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                rst,
`ifdef MAT_POW_DISPATCHER_PERF_CNT_EN
    output logic [15:0]         jobs_done,
    output logic [15:0]         jobs_err,
    output logic [31:0]         wait_cycles,
`endif
    mat_pow_dispatcher_if.master bus
);
    localparam int unsigned DW = ELEM_W * ELEMS;

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StDrain} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] op_mat_q, op_mat_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_mat_q, rsp_mat_d;
    logic          rsp_err_q, rsp_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_mat_q    <= '0;
            wd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_mat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_mat_q    <= op_mat_d;
            wd_q        <= wd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_mat_q   <= rsp_mat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_mat_d    = op_mat_q;
        wd_d        = wd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_mat_d   = rsp_mat_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    op_mat_d = bus.req_mat;
                    state_d  = StLoad;
                end
            end
            StLoad: state_d = StStart;
            StStart: begin
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                wd_d = wd_q + TO_W'(1);
                // A Ready arriving in the expiry cycle still counts as success
                if (bus.core_ready) begin
                    rsp_mat_d   = bus.core_result;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StDrain;
                end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
                    rsp_mat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = StDrain;
                end
            end
            StDrain: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.op_start  = (state_q == StStart);
    assign bus.busy      = (state_q != StIdle);
    assign bus.op_mat    = op_mat_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_mat   = rsp_mat_q;
    assign bus.rsp_err   = rsp_err_q;

`ifdef MAT_POW_DISPATCHER_PERF_CNT_EN
    logic [15:0] jobs_done_q, jobs_err_q;
    logic [31:0] wait_cycles_q;
    logic        drain_exit;

    assign drain_exit = (state_q == StDrain) && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            jobs_done_q   <= '0;
            jobs_err_q    <= '0;
            wait_cycles_q <= '0;
        end else begin
            if (drain_exit && !rsp_err_q && (jobs_done_q != '1)) jobs_done_q <= jobs_done_q + 16'd1;
            if (drain_exit && rsp_err_q && (jobs_err_q != '1)) jobs_err_q <= jobs_err_q + 16'd1;
            if ((state_q == StWait) && (wait_cycles_q != '1)) begin
                wait_cycles_q <= wait_cycles_q + 32'd1;
            end
        end
    end

    assign jobs_done   = jobs_done_q;
    assign jobs_err    = jobs_err_q;
    assign wait_cycles = wait_cycles_q;
`else
    // Counters absent in this build.
`endif
endmodule

// File: tb/tb_mat_pow_dispatcher.sv
// Randomized self-checking bench for mat_pow_dispatcher against a job-level reference model.
// Honours MAT_POW_DISPATCHER_PERF_CNT_EN for the optional counters.
module tb_mat_pow_dispatcher;
    localparam int unsigned ELEM_W  = 8;
    localparam int unsigned ELEMS   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model of the optional counters
    int   m_done = 0;
    int   m_err  = 0;
    int   m_wait = 0;

    mat_pow_dispatcher_if #(.ELEM_W(ELEM_W), .ELEMS(ELEMS)) bus ();

`ifdef MAT_POW_DISPATCHER_PERF_CNT_EN
    logic [15:0] jobs_done;
    logic [15:0] jobs_err;
    logic [31:0] wait_cycles;
`endif

    mat_pow_dispatcher #(
        .ELEM_W (ELEM_W),
        .ELEMS  (ELEMS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef MAT_POW_DISPATCHER_PERF_CNT_EN
        .jobs_done  (jobs_done),
        .jobs_err   (jobs_err),
        .wait_cycles(wait_cycles),
`endif
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "bench time limit expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // lat: WAIT cycle (1-based) in which core_ready is raised; lat > TIMEOUT means never.
    task automatic run_job(input logic [31:0] mat, input int lat, input logic [31:0] res,
                           input int hold, input bit stray);
        bit          exp_err;
        int          wc;
        logic [31:0] exp_mat;
        exp_err = (lat > int'(TIMEOUT));
        wc      = exp_err ? int'(TIMEOUT) : lat;
        exp_mat = exp_err ? 32'h0 : res;

        check_eq("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_mat   = mat;
        tick();
        // LOAD
        bus.req_valid = 1'b0;
        bus.req_mat   = $urandom;
        check_eq("op_mat_load", bus.op_mat, mat);
        check_eq("op_start_load", bus.op_start, 0);
        check_eq("req_ready_load", bus.req_ready, 0);
        check_eq("busy_load", bus.busy, 1);
        bus.core_ready  = stray;
        bus.core_result = $urandom;
        tick();
        // START
        check_eq("op_start_start", bus.op_start, 1);
        check_eq("rsp_valid_start", bus.rsp_valid, 0);
        bus.core_ready  = stray;
        bus.core_result = $urandom;
        tick();
        for (int i = 1; i <= wc; i++) begin
            check_eq("op_start_wait", bus.op_start, 0);
            check_eq("rsp_valid_wait", bus.rsp_valid, 0);
            bus.core_ready  = (i == lat);
            bus.core_result = (i == lat) ? res : $urandom;
            tick();
        end
        bus.core_ready = 1'b0;
        check_eq("rsp_valid_drain", bus.rsp_valid, 1);
        check_eq("rsp_mat", bus.rsp_mat, exp_mat);
        check_eq("rsp_err", bus.rsp_err, exp_err);
        check_eq("req_ready_drain", bus.req_ready, 0);
        // Backpressure with a competing request that must not be taken
        bus.req_valid = (hold > 0);
        bus.req_mat   = ~mat;
        for (int k = 0; k < hold; k++) begin
            bus.rsp_ready = 1'b0;
            tick();
            check_eq("rsp_valid_hold", bus.rsp_valid, 1);
            check_eq("rsp_mat_hold", bus.rsp_mat, exp_mat);
            check_eq("rsp_err_hold", bus.rsp_err, exp_err);
            check_eq("req_ready_hold", bus.req_ready, 0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check_eq("rsp_valid_done", bus.rsp_valid, 0);
        check_eq("req_ready_done", bus.req_ready, 1);
        check_eq("busy_done", bus.busy, 0);
        check_eq("op_mat_kept", bus.op_mat, mat);
        if (exp_err) m_err++;
        else m_done++;
        m_wait += wc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_op_mat"}, bus.op_mat, 0);
        check_eq({tag, "_op_start"}, bus.op_start, 0);
        check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check_eq({tag, "_rsp_mat"}, bus.rsp_mat, 0);
        check_eq({tag, "_rsp_err"}, bus.rsp_err, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_mat     = '0;
        bus.core_ready  = 1'b0;
        bus.core_result = '0;
        bus.rsp_ready   = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        check_eq("rst_req_ready", bus.req_ready, 1);

        // Reset in the middle of WAIT drops the job
        bus.req_valid = 1'b1;
        bus.req_mat   = 32'hDEADBEEF;
        tick();
        bus.req_valid = 1'b0;
        repeat (5) tick();
        check_eq("pre_rst_busy", bus.busy, 1);
        rst             = 1'b1;
        bus.core_result = 32'h12345678;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_outputs("rst_mid");
        check_eq("rst_mid_req_ready", bus.req_ready, 1);
        m_done = 0;
        m_err  = 0;
        m_wait = 0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("dropped_no_rsp", bus.rsp_valid, 0);
        end
        bus.rsp_ready = 1'b0;

        // Stray Ready while idle
        for (int i = 0; i < 4; i++) begin
            bus.core_ready  = 1'b1;
            bus.core_result = $urandom;
            tick();
            check_eq("stray_idle_busy", bus.busy, 0);
            check_eq("stray_idle_rsp", bus.rsp_valid, 0);
        end
        bus.core_ready = 1'b0;

        run_job(32'h04030201, 5, 32'h1D140F0A, 0, 1'b0);     // nominal
        run_job($urandom, 3, $urandom, 10, 1'b0);            // backpressure
        run_job($urandom, 1000, $urandom, 1, 1'b0);          // timeout
        run_job($urandom, 2, $urandom, 0, 1'b0);             // recovery
        run_job($urandom, int'(TIMEOUT), $urandom, 2, 1'b1); // race + stray in LOAD/START

        for (int j = 0; j < 24; j++) begin
            run_job($urandom, int'($urandom_range(1, TIMEOUT + 3)), $urandom,
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

`ifdef MAT_POW_DISPATCHER_PERF_CNT_EN
        check_eq("jobs_done", jobs_done, 64'(m_done));
        check_eq("jobs_err", jobs_err, 64'(m_err));
        check_eq("wait_cycles", wait_cycles, 64'(m_wait));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
